// File: rtl/mem_trans_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_trans_gen
// Description : Transaction sequencer for the memory checker. Walks a
//               programmed number of address steps. Each step consumes the
//               current address from the address generator and issues a
//               write, a read, or a write followed by a read over a
//               valid/ready command port. It then strobes the address
//               generator to advance.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_trans_gen #(
  parameter int ADDR_W = 24,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              test_start_i,
  input  logic [1:0]        test_mode_i,
  input  logic [CNT_W-1:0]  trans_amount_i,
  input  logic [ADDR_W-1:0] next_addr_i,
  output logic              next_addr_en_o,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic              cmd_write_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  trans_cnt_o
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_LOAD  = 2'd1;
  localparam logic [1:0] c_ISSUE = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam logic [1:0] c_MODE_RD  = 2'd1;
  localparam logic [1:0] c_MODE_WR2 = 2'd2;
  localparam logic [1:0] c_MODE_RSV = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [1:0]        r_mode;
  logic [CNT_W-1:0]  r_amount;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_phase;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;

  logic              w_start_ok;
  logic              w_hs;
  logic              w_last_phase;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_final;

  // A start is only accepted from IDLE and never for the reserved mode.
  assign w_start_ok   = (r_state == c_IDLE) && test_start_i && (test_mode_i != c_MODE_RSV);
  assign w_hs         = (r_state == c_ISSUE) && cmd_ready_i;
  // Only write-then-read has two phases per address; the read is the last.
  assign w_last_phase = (r_mode != c_MODE_WR2) || r_phase;
  assign w_cnt_inc    = r_cnt + 1'b1;
  assign w_final      = (w_cnt_inc == r_amount);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = (trans_amount_i == '0) ? c_DONE : c_LOAD;
        end
      end
      c_LOAD: begin
        w_state_nxt = c_ISSUE;
      end
      c_ISSUE: begin
        if (w_hs && w_last_phase) begin
          w_state_nxt = w_final ? c_DONE : c_LOAD;
        end
      end
      c_DONE: begin
        w_state_nxt = c_IDLE;
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  // State-decoded outputs; the advance strobe is never raised for the final step.
  always_comb begin
    cmd_valid_o    = 1'b0;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    next_addr_en_o = 1'b0;
    cmd_valid_o    = (r_state == c_ISSUE);
    busy_o         = (r_state != c_IDLE);
    done_o         = (r_state == c_DONE);
    next_addr_en_o = w_hs && w_last_phase && !w_final;
  end

  // Test context, command fields and completed-step counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mode   <= 2'd0;
      r_amount <= '0;
      r_cnt    <= '0;
      r_phase  <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_start_ok) begin
            r_mode   <= test_mode_i;
            r_amount <= trans_amount_i;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
          end
        end
        c_LOAD: begin
          r_addr  <= next_addr_i;
          r_write <= (r_mode != c_MODE_RD) && !r_phase;
        end
        c_ISSUE: begin
          if (w_hs) begin
            if (!w_last_phase) begin
              // Write half of a write-then-read step: keep the address, turn around to read.
              r_phase <= 1'b1;
              r_write <= 1'b0;
            end else begin
              r_cnt   <= w_cnt_inc;
              r_phase <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cmd_write_o = r_write;
  assign cmd_addr_o  = r_addr;
  assign trans_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_trans_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_trans_gen
// Description : Scoreboard bench for mem_trans_gen. Tests queue expected
//               commands. A monitor pops and compares every handshake and
//               gathers strobe statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_trans_gen;

  localparam int ADDR_W = 24;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              test_start;
  logic [1:0]        test_mode;
  logic [CNT_W-1:0]  trans_amount;
  logic [ADDR_W-1:0] ag_addr;
  logic [ADDR_W-1:0] ag_base;
  logic              next_addr_en;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  trans_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int en_cnt, done_cnt, hs_cnt, first_valid_cyc, last_hs_cyc, done_cyc;
  logic [1:0]        cur_mode;
  logic              prev_stall;
  logic [ADDR_W-1:0] prev_addr;
  logic              prev_write;
  logic [ADDR_W:0]   exp_cmd;
  logic [ADDR_W:0]   sb[$];

  mem_trans_gen #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .test_start_i   (test_start),
    .test_mode_i    (test_mode),
    .trans_amount_i (trans_amount),
    .next_addr_i    (ag_addr),
    .next_addr_en_o (next_addr_en),
    .cmd_valid_o    (cmd_valid),
    .cmd_ready_i    (cmd_ready),
    .cmd_write_o    (cmd_write),
    .cmd_addr_o     (cmd_addr),
    .busy_o         (busy),
    .done_o         (done),
    .trans_cnt_o    (trans_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Incrementing address generator; like the real one it ignores starts while busy.
  always @(posedge clk or posedge rst) begin
    if (rst) ag_addr <= '0;
    else if (test_start && !busy) ag_addr <= ag_base;
    else if (next_addr_en) ag_addr <= ag_addr + 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_cmd(input logic w, input logic [ADDR_W-1:0] a);
    sb.push_back({w, a});
  endtask

  // Monitor: compares each handshake against the scoreboard and tracks strobes.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (cmd_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (cmd_valid && prev_stall) begin
        check("stall_addr_stable", 32'(cmd_addr), 32'(prev_addr));
        check("stall_write_stable", 32'(cmd_write), 32'(prev_write));
      end
      prev_stall = cmd_valid && !cmd_ready;
      prev_addr  = cmd_addr;
      prev_write = cmd_write;
      if (cmd_valid && cmd_ready) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_cmd: got write=%0d addr=0x%0h expected no command", cmd_write, cmd_addr);
        end else begin
          exp_cmd = sb.pop_front();
          check("cmd_write_addr", 32'({cmd_write, cmd_addr}), 32'(exp_cmd));
        end
      end
      if (next_addr_en) begin
        en_cnt++;
        check("en_with_handshake", 32'(cmd_valid && cmd_ready), 32'd1);
        if (cur_mode == 2'd2) check("en_after_read", 32'(cmd_write), 32'd0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_stats(input logic [1:0] m);
    cur_mode        = m;
    en_cnt          = 0;
    done_cnt        = 0;
    hs_cnt          = 0;
    first_valid_cyc = -1;
    last_hs_cyc     = -1;
    done_cyc        = -1;
  endtask

  // Pulses start for one cycle; returns the cycle index T of the pulse.
  // Inputs are scrambled afterwards to show the DUT latched them.
  task automatic pulse_start(input logic [1:0] m, input logic [CNT_W-1:0] amt,
                             input logic [ADDR_W-1:0] base, output int t);
    @(posedge clk); #1;
    ag_base      = base;
    test_mode    = m;
    trans_amount = amt;
    test_start   = 1'b1;
    t            = cyc;
    @(posedge clk); #1;
    test_start   = 1'b0;
    test_mode    = m ^ 2'd1;
    trans_amount = amt + 16'd5;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done_o expected done_o within %0d cycles", budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic end_checks(input int exp_cnt, input int exp_en);
    check("trans_cnt", 32'(trans_cnt), 32'(exp_cnt));
    check("next_addr_en_pulses", 32'(en_cnt), 32'(exp_en));
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_write"}, 32'(cmd_write), 32'd0);
    check({tag, "_en"},    32'(next_addr_en), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_addr"},  32'(cmd_addr), 32'd0);
    check({tag, "_cnt"},   32'(trans_cnt), 32'd0);
  endtask

  initial begin
    int t;
    bit seen;
    rst          = 1'b1;
    test_start   = 1'b0;
    test_mode    = 2'd0;
    trans_amount = '0;
    cmd_ready    = 1'b0;
    ag_base      = '0;
    prev_stall   = 1'b0;
    clear_stats(2'd0);
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Mode 0, amount 4, ready tied high: writes 0x100..0x103.
    clear_stats(2'd0);
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) expect_cmd(1'b1, 24'h100 + 24'(i));
    pulse_start(2'd0, 16'd4, 24'h100, t);
    wait_done(60);
    check("m0_first_valid", 32'(first_valid_cyc), 32'(t + 2));
    check("m0_last_hs", 32'(last_hs_cyc), 32'(first_valid_cyc + 6));
    check("m0_done_timing", 32'(done_cyc), 32'(last_hs_cyc + 1));
    end_checks(4, 3);

    // Reserved mode: ignored, count from previous test held.
    clear_stats(2'd3);
    pulse_start(2'd3, 16'd5, 24'h400, t);
    repeat (4) begin
      @(negedge clk);
      check("m3_busy", 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
    check("m3_no_done", 32'(done_cnt), 32'd0);
    check("m3_no_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);
    check("m3_cnt_held", 32'(trans_cnt), 32'd4);

    // Mode 2, amount 2: W100 R100 W101 R101, one advance after the first read.
    clear_stats(2'd2);
    expect_cmd(1'b1, 24'h100);
    expect_cmd(1'b0, 24'h100);
    expect_cmd(1'b1, 24'h101);
    expect_cmd(1'b0, 24'h101);
    pulse_start(2'd2, 16'd2, 24'h100, t);
    wait_done(60);
    check("m2_first_valid", 32'(first_valid_cyc), 32'(t + 2));
    check("m2_last_hs", 32'(last_hs_cyc), 32'(first_valid_cyc + 4));
    check("m2_done_timing", 32'(done_cyc), 32'(last_hs_cyc + 1));
    end_checks(2, 1);

    // Mode 1, amount 3, each command stalled 5 cycles before ready.
    clear_stats(2'd1);
    cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) expect_cmd(1'b0, 24'h180 + 24'(i));
    pulse_start(2'd1, 16'd3, 24'h180, t);
    for (int s = 0; s < 3; s++) begin
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (cmd_valid) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        checks++;
        failures++;
        $display("FAIL m1_valid_timeout: got no cmd_valid_o expected one for step %0d", s);
      end
      repeat (5) @(posedge clk);
      #1 cmd_ready = 1'b1;
      @(posedge clk); #1;
      cmd_ready = 1'b0;
    end
    wait_done(40);
    end_checks(3, 2);

    // Amount 0: done at T+1, no commands, no advance.
    clear_stats(2'd0);
    cmd_ready = 1'b1;
    pulse_start(2'd0, 16'd0, 24'h000, t);
    wait_done(10);
    check("a0_done_timing", 32'(done_cyc), 32'(t + 1));
    check("a0_no_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);
    end_checks(0, 0);

    // Second start while busy is ignored.
    clear_stats(2'd0);
    for (int i = 0; i < 3; i++) expect_cmd(1'b1, 24'h200 + 24'(i));
    pulse_start(2'd0, 16'd3, 24'h200, t);
    @(posedge clk); #1;
    ag_base      = 24'h999;
    test_mode    = 2'd2;
    trans_amount = 16'd7;
    test_start   = 1'b1;
    @(posedge clk); #1;
    test_start   = 1'b0;
    wait_done(60);
    end_checks(3, 2);

    // Reset after 2 of 5 steps, then a clean new test.
    clear_stats(2'd0);
    for (int i = 0; i < 5; i++) expect_cmd(1'b1, 24'h300 + 24'(i));
    pulse_start(2'd0, 16'd5, 24'h300, t);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (trans_cnt == 16'd2) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL rst_wait_timeout: got trans_cnt=%0d expected 2", trans_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    clear_stats(2'd0);
    expect_cmd(1'b1, 24'h310);
    expect_cmd(1'b1, 24'h311);
    pulse_start(2'd0, 16'd2, 24'h310, t);
    wait_done(40);
    check("post_rst_first_valid", 32'(first_valid_cyc), 32'(t + 2));
    end_checks(2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
